// File: rtl/tmr_pkg.sv
// Shared definitions for the timer input path: edge-select encoding,
// synchroniser depth floor and the edge-selection helper.
package tmr_pkg;

  localparam int SYNC_MIN = 2;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_sel_e;

  function automatic logic edge_hit(edge_sel_e sel, logic rise, logic fall);
    logic hit;
    hit = 1'b0;
    case (sel)
      EDGE_RISE: hit = rise;
      EDGE_FALL: hit = fall;
      EDGE_BOTH: hit = rise | fall;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/tmr_in_cond_if.sv
// Pin, configuration and status bundle of the timer input conditioner.
// The register file / bench side is master, the conditioner is slave.
interface tmr_in_cond_if #(
  parameter int filt_w = 8,
  parameter int cnt_w  = 16
);

  logic              in_raw;
  logic              filt_en;
  logic [filt_w-1:0] filt_len;
  logic [1:0]        edge_sel;
  logic              cnt_clr;
  logic              in_filt;
  logic              edge_pulse;
  logic [cnt_w-1:0]  edge_cnt;
  logic              cnt_ovf;

  modport master (
    output in_raw, filt_en, filt_len, edge_sel, cnt_clr,
    input  in_filt, edge_pulse, edge_cnt, cnt_ovf
  );

  modport slave (
    input  in_raw, filt_en, filt_len, edge_sel, cnt_clr,
    output in_filt, edge_pulse, edge_cnt, cnt_ovf
  );

endinterface

// File: rtl/tmr_sync.sv
// Generic N-flop synchroniser for an asynchronous pin; depth is never
// allowed below SYNC_MIN so a bad parameter cannot remove the metastability guard.
module tmr_sync
  import tmr_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  localparam int N = (STAGES < SYNC_MIN) ? SYNC_MIN : STAGES;

  logic [N-1:0] chain_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[N-2:0], d_i};
    end
  end

  assign q_o = chain_q[N-1];

endmodule

// File: rtl/tmr_in_cond.sv
// Timer capture input conditioner: synchronise, glitch-filter, detect the
// selected edges and count them; in_filt feeds the timer's tmr_in pin.
module tmr_in_cond
  import tmr_pkg::*;
#(
  parameter int sync_stages = 2,
  parameter int filt_w      = 8,
  parameter int cnt_w       = 16
) (
  input logic         clk,
  input logic         rst,
  tmr_in_cond_if.slave bus
);

  logic              s;
  logic              in_filt_q, in_filt_d;
  logic [filt_w-1:0] stab_q, stab_d;
  logic              prev_q;
  logic              pulse_q, pulse_d;
  logic [cnt_w-1:0]  cnt_q;
  logic              ovf_q;
  logic              rise, fall;

  tmr_sync #(
    .STAGES(sync_stages)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d_i(bus.in_raw),
    .q_o(s)
  );

  // The >= compare keeps a shrinking filt_len safe: stab never passes it.
  always_comb begin
    in_filt_d = in_filt_q;
    stab_d    = stab_q;
    if (!bus.filt_en) begin
      in_filt_d = s;
      stab_d    = '0;
    end else if (s == in_filt_q) begin
      stab_d = '0;
    end else if (stab_q >= bus.filt_len) begin
      in_filt_d = s;
      stab_d    = '0;
    end else begin
      stab_d = stab_q + filt_w'(1);
    end
  end

  assign rise    = in_filt_q & ~prev_q;
  assign fall    = ~in_filt_q & prev_q;
  assign pulse_d = edge_hit(edge_sel_e'(bus.edge_sel), rise, fall);

  // Counter steps on the same edge that raises edge_pulse; clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_filt_q <= 1'b0;
      stab_q    <= '0;
      prev_q    <= 1'b0;
      pulse_q   <= 1'b0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      in_filt_q <= in_filt_d;
      stab_q    <= stab_d;
      prev_q    <= in_filt_q;
      pulse_q   <= pulse_d;
      if (bus.cnt_clr) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else if (pulse_d) begin
        cnt_q <= cnt_q + cnt_w'(1);
        if (cnt_q == '1) begin
          ovf_q <= 1'b1;
        end
      end
    end
  end

  assign bus.in_filt    = in_filt_q;
  assign bus.edge_pulse = pulse_q;
  assign bus.edge_cnt   = cnt_q;
  assign bus.cnt_ovf    = ovf_q;

endmodule

// File: tb/tb_tmr_in_cond.sv
// Self-checking bench for tmr_in_cond: table of pulse-train vectors plus
// hand sequences for latency, wrap, clear priority and mid-filter reset.
module tb_tmr_in_cond;

  localparam int FW = 8;
  localparam int CW = 4;

  logic clk;
  logic rst;

  tmr_in_cond_if #(.filt_w(FW), .cnt_w(CW)) bus ();

  tmr_in_cond #(
    .sync_stages(2),
    .filt_w(FW),
    .cnt_w(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          en;
    logic [FW-1:0] len;
    logic [1:0]    sel;
    int            hi;
    int            lo;
    int            n;
    int            expHigh;
    int            expPulses;
    int            expCnt;
  } vec_t;

  typedef struct {
    string name;
    int    value;
  } exp_t;

  exp_t expQ[$];
  int   checks   = 0;
  int   failures = 0;
  int   pulseCount = 0;
  int   highCount  = 0;

  always @(negedge clk) begin
    if (bus.edge_pulse === 1'b1) pulseCount++;
    if (bus.in_filt === 1'b1) highCount++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(string name, int value);
    exp_t e;
    e.name  = name;
    e.value = value;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(int actual);
    exp_t e;
    checks++;
    if (expQ.size() == 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_empty: got %0d, nothing expected", actual);
    end else begin
      e = expQ.pop_front();
      if (actual != e.value) begin
        failures++;
        $display("[TB] FAIL %s: got %0d, expected %0d", e.name, actual, e.value);
      end
    end
  endtask

  task automatic applyStimulus(vec_t v, int idx);
    int p0, h0;
    bus.filt_en  = v.en;
    bus.filt_len = v.len;
    bus.edge_sel = v.sel;
    bus.cnt_clr  = 1'b1;
    tick();
    bus.cnt_clr  = 1'b0;
    p0 = pulseCount;
    h0 = highCount;
    pushExp($sformatf("vec%0d_in_filt_seen", idx), v.expHigh);
    pushExp($sformatf("vec%0d_pulses", idx), v.expPulses);
    pushExp($sformatf("vec%0d_edge_cnt", idx), v.expCnt);
    for (int k = 0; k < v.n; k++) begin
      bus.in_raw = 1'b1;
      repeat (v.hi) tick();
      bus.in_raw = 1'b0;
      repeat (v.lo) tick();
    end
    repeat (20) tick();
    checkOutput((highCount - h0) > 0 ? 1 : 0);
    checkOutput(pulseCount - p0);
    checkOutput(int'(bus.edge_cnt));
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b1, 8'd4, 2'b01, 4, 10, 1, 0, 0, 0};
    vecs[1] = '{1'b1, 8'd4, 2'b01, 5, 10, 1, 1, 1, 1};
    vecs[2] = '{1'b0, 8'd0, 2'b11, 3, 5, 3, 1, 6, 6};
    vecs[3] = '{1'b1, 8'd0, 2'b11, 3, 5, 3, 1, 6, 6};
    vecs[4] = '{1'b1, 8'd0, 2'b10, 3, 5, 3, 1, 3, 3};
    vecs[5] = '{1'b1, 8'd2, 2'b00, 6, 8, 2, 1, 0, 0};
    vecs[6] = '{1'b0, 8'd9, 2'b01, 1, 4, 2, 1, 2, 2};
    vecs[7] = '{1'b1, 8'd2, 2'b11, 2, 6, 2, 0, 0, 0};

    // Reset with the pin high must still give all-zero state.
    rst          = 1'b1;
    bus.in_raw   = 1'b1;
    bus.filt_en  = 1'b0;
    bus.filt_len = '0;
    bus.edge_sel = 2'b01;
    bus.cnt_clr  = 1'b0;
    repeat (3) tick();
    pushExp("reset_in_filt", 0);
    pushExp("reset_edge_pulse", 0);
    pushExp("reset_edge_cnt", 0);
    pushExp("reset_cnt_ovf", 0);
    checkOutput(int'(bus.in_filt));
    checkOutput(int'(bus.edge_pulse));
    checkOutput(int'(bus.edge_cnt));
    checkOutput(int'(bus.cnt_ovf));
    bus.in_raw = 1'b0;
    tick();
    rst = 1'b0;
    repeat (5) tick();

    $display("[TB] bypass latency");
    bus.cnt_clr = 1'b1;
    tick();
    bus.cnt_clr = 1'b0;
    tick();
    bus.in_raw = 1'b1;
    tick();
    tick();
    pushExp("bypass_in_filt_e2", 0);
    checkOutput(int'(bus.in_filt));
    tick();
    pushExp("bypass_in_filt_e3", 1);
    pushExp("bypass_pulse_e3", 0);
    checkOutput(int'(bus.in_filt));
    checkOutput(int'(bus.edge_pulse));
    tick();
    pushExp("bypass_pulse_e4", 1);
    pushExp("bypass_cnt_e4", 1);
    checkOutput(int'(bus.edge_pulse));
    checkOutput(int'(bus.edge_cnt));
    tick();
    pushExp("bypass_pulse_e5", 0);
    checkOutput(int'(bus.edge_pulse));
    bus.in_raw = 1'b0;
    repeat (10) tick();

    $display("[TB] vector table");
    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);

    $display("[TB] wrap and overflow");
    bus.filt_en  = 1'b0;
    bus.edge_sel = 2'b01;
    bus.cnt_clr  = 1'b1;
    tick();
    bus.cnt_clr  = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      bus.in_raw = 1'b1;
      repeat (2) tick();
      bus.in_raw = 1'b0;
      repeat (4) tick();
      if (i == 15 || i == 16 || i == 17) begin
        pushExp($sformatf("wrap_cnt_after_%0d", i), (i == 15) ? 15 : (i == 16) ? 0 : 1);
        pushExp($sformatf("wrap_ovf_after_%0d", i), (i == 15) ? 0 : 1);
        checkOutput(int'(bus.edge_cnt));
        checkOutput(int'(bus.cnt_ovf));
      end
    end
    bus.cnt_clr = 1'b1;
    tick();
    bus.cnt_clr = 1'b0;
    pushExp("clr_cnt", 0);
    pushExp("clr_ovf", 0);
    checkOutput(int'(bus.edge_cnt));
    checkOutput(int'(bus.cnt_ovf));

    $display("[TB] clear priority");
    tick();
    bus.in_raw = 1'b1;
    repeat (3) tick();
    bus.cnt_clr = 1'b1;
    tick();
    bus.cnt_clr = 1'b0;
    pushExp("prio_pulse", 1);
    pushExp("prio_cnt", 0);
    checkOutput(int'(bus.edge_pulse));
    checkOutput(int'(bus.edge_cnt));
    tick();
    pushExp("prio_cnt_next", 0);
    checkOutput(int'(bus.edge_cnt));
    bus.in_raw = 1'b0;
    repeat (10) tick();

    $display("[TB] reset mid-filter");
    bus.in_raw = 1'b1;
    repeat (3) tick();
    bus.in_raw = 1'b0;
    repeat (8) tick();
    pushExp("pre_reset_cnt", 1);
    checkOutput(int'(bus.edge_cnt));
    bus.filt_en  = 1'b1;
    bus.filt_len = 8'd8;
    tick();
    bus.in_raw = 1'b1;
    repeat (7) tick();
    rst = 1'b1;
    #1;
    pushExp("rst_in_filt", 0);
    pushExp("rst_pulse", 0);
    pushExp("rst_cnt", 0);
    pushExp("rst_ovf", 0);
    checkOutput(int'(bus.in_filt));
    checkOutput(int'(bus.edge_pulse));
    checkOutput(int'(bus.edge_cnt));
    checkOutput(int'(bus.cnt_ovf));
    tick();
    rst = 1'b0;
    repeat (10) tick();
    pushExp("post_rst_in_filt_r10", 0);
    checkOutput(int'(bus.in_filt));
    tick();
    pushExp("post_rst_in_filt_r11", 1);
    pushExp("post_rst_pulse_r11", 0);
    checkOutput(int'(bus.in_filt));
    checkOutput(int'(bus.edge_pulse));
    tick();
    pushExp("post_rst_pulse_r12", 1);
    pushExp("post_rst_cnt_r12", 1);
    checkOutput(int'(bus.edge_pulse));
    checkOutput(int'(bus.edge_cnt));
    repeat (5) tick();
    pushExp("post_rst_cnt_final", 1);
    checkOutput(int'(bus.edge_cnt));
    bus.in_raw = 1'b0;
    repeat (3) tick();

    if (expQ.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_leftover: got %0d pending, expected 0", expQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
